// File: rtl/conv33_mac_pipe_pkg.sv
// Shared constants and the requantize helper for the 3x3 convolution MAC pipeline.
package conv33_pkg;

    localparam int KTAPS          = 9;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 20;
    localparam int SAT_MAX        = (2 ** (DEF_DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN        = -(2 ** (DEF_DATA_WIDTH - 1));

    // Worked at 64 bits so the round-half-up add never overflows for any legal ACC_WIDTH.
    function automatic logic signed [63:0] requantize(input logic signed [63:0] acc,
                                                      input int shift,
                                                      input int dw);
        logic signed [63:0] q;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (shift == 0)
            q = acc;
        else
            q = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        if (q > hi)
            q = hi;
        else if (q < lo)
            q = lo;
        return q;
    endfunction

endpackage

// File: rtl/conv33_row_mac.sv
// One kernel row: three signed products (S1) reduced to a sign-extended row sum (S2).
module conv33_row_mac
    import conv33_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv,
    input  logic [DATA_WIDTH-1:0] w0,
    input  logic [DATA_WIDTH-1:0] w1,
    input  logic [DATA_WIDTH-1:0] w2,
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] x1,
    input  logic [DATA_WIDTH-1:0] x2,
    output logic [ACC_WIDTH-1:0]  row_sum
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        prod_p0 [3];
    logic signed [ACC_WIDTH-1:0] row_sum_p1;

    function automatic logic signed [PW-1:0] smul(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
        return PW'($signed(a)) * PW'($signed(b));
    endfunction

    // S1 -> S2 boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_p0[0] <= '0;
            prod_p0[1] <= '0;
            prod_p0[2] <= '0;
            row_sum_p1 <= '0;
        end else if (adv) begin
            prod_p0[0] <= smul(w0, x0);
            prod_p0[1] <= smul(w1, x1);
            prod_p0[2] <= smul(w2, x2);
            row_sum_p1 <= ACC_WIDTH'(prod_p0[0]) + ACC_WIDTH'(prod_p0[1]) + ACC_WIDTH'(prod_p0[2]);
        end
    end

    assign row_sum = row_sum_p1;

endmodule

// File: rtl/conv33_mac_pipe.sv
// 4-stage 3x3 convolution MAC: products, row sums, biased accumulate, requantize/saturate.
// Define CONV33_MAC_RELU_EN to clamp negative out_data to zero (out_acc unaffected).
module conv33_mac_pipe
    import conv33_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SHIFT      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] weight_0,
    input  logic [DATA_WIDTH-1:0] weight_1,
    input  logic [DATA_WIDTH-1:0] weight_2,
    input  logic [DATA_WIDTH-1:0] weight_3,
    input  logic [DATA_WIDTH-1:0] weight_4,
    input  logic [DATA_WIDTH-1:0] weight_5,
    input  logic [DATA_WIDTH-1:0] weight_6,
    input  logic [DATA_WIDTH-1:0] weight_7,
    input  logic [DATA_WIDTH-1:0] weight_8,
    input  logic                  weight_valid,
    input  logic [DATA_WIDTH-1:0] pix_0,
    input  logic [DATA_WIDTH-1:0] pix_1,
    input  logic [DATA_WIDTH-1:0] pix_2,
    input  logic [DATA_WIDTH-1:0] pix_3,
    input  logic [DATA_WIDTH-1:0] pix_4,
    input  logic [DATA_WIDTH-1:0] pix_5,
    input  logic [DATA_WIDTH-1:0] pix_6,
    input  logic [DATA_WIDTH-1:0] pix_7,
    input  logic [DATA_WIDTH-1:0] pix_8,
    input  logic [ACC_WIDTH-1:0]  bias,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ACC_WIDTH-1:0]  out_acc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  kernel_loaded
);

    logic [DATA_WIDTH-1:0]       w_in    [KTAPS];
    logic [DATA_WIDTH-1:0]       pix_win [KTAPS];
    logic [DATA_WIDTH-1:0]       kernel  [KTAPS];
    logic [ACC_WIDTH-1:0]        row_sum [3];
    logic                        adv;
    logic                        accept;
    logic                        vld_p0, vld_p1, vld_p2;
    logic signed [ACC_WIDTH-1:0] bias_p0, bias_p1, acc_p2;
    logic signed [DATA_WIDTH-1:0] q_p2;

    assign w_in    = '{weight_0, weight_1, weight_2, weight_3, weight_4,
                       weight_5, weight_6, weight_7, weight_8};
    assign pix_win = '{pix_0, pix_1, pix_2, pix_3, pix_4, pix_5, pix_6, pix_7, pix_8};

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = kernel_loaded && adv;
    assign accept   = in_valid && in_ready;

    // Kernel latching ignores stalls; S1 samples the old kernel on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KTAPS; i++)
                kernel[i] <= '0;
            kernel_loaded <= 1'b0;
        end else if (weight_valid) begin
            for (int i = 0; i < KTAPS; i++)
                kernel[i] <= w_in[i];
            kernel_loaded <= 1'b1;
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        conv33_row_mac #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_row (
            .clk     (clk),
            .rst     (rst),
            .adv     (adv),
            .w0      (kernel[3*r]),
            .w1      (kernel[3*r+1]),
            .w2      (kernel[3*r+2]),
            .x0      (pix_win[3*r]),
            .x1      (pix_win[3*r+1]),
            .x2      (pix_win[3*r+2]),
            .row_sum (row_sum[r])
        );
    end

    always_comb begin
        q_p2 = DATA_WIDTH'(requantize({{(64-ACC_WIDTH){acc_p2[ACC_WIDTH-1]}}, acc_p2},
                                      SHIFT, DATA_WIDTH));
`ifdef CONV33_MAC_RELU_EN
        if (q_p2[DATA_WIDTH-1])
            q_p2 = '0;
`endif
    end

    // S1 (bias) -> S2 -> S3 (acc) -> S4 (outputs)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            bias_p0   <= '0;
            bias_p1   <= '0;
            acc_p2    <= '0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_data  <= '0;
        end else if (adv) begin
            vld_p0    <= accept;
            bias_p0   <= bias;
            vld_p1    <= vld_p0;
            bias_p1   <= bias_p0;
            vld_p2    <= vld_p1;
            acc_p2    <= row_sum[0] + row_sum[1] + row_sum[2] + bias_p1;
            out_valid <= vld_p2;
            out_acc   <= acc_p2;
            out_data  <= q_p2;
        end
    end

endmodule

// File: tb/tb_conv33_mac_pipe.sv
// Self-checking bench: SHIFT=0 and SHIFT=2 instances share stimulus and a transaction-level model.
module tb_conv33_mac_pipe;
    import conv33_pkg::*;

    localparam int DW = 8;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] weight [9];
    logic [DW-1:0] pix    [9];
    logic          weight_valid = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] bias = '0;

    logic          in_ready0, out_valid0, kernel_loaded0;
    logic [DW-1:0] out_data0;
    logic [AW-1:0] out_acc0;
    logic          in_ready2, out_valid2, kernel_loaded2;
    logic [DW-1:0] out_data2;
    logic [AW-1:0] out_acc2;

    int n_cmp = 0;
    int n_bad = 0;

    bit     m_vld [4];
    longint m_acc [4];
    longint m_k   [9];
    bit     m_loaded;
    longint q_acc[$];
    longint q_d0[$];
    longint q_d2[$];

    always #5 clk = ~clk;

    conv33_mac_pipe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst),
        .weight_0(weight[0]), .weight_1(weight[1]), .weight_2(weight[2]),
        .weight_3(weight[3]), .weight_4(weight[4]), .weight_5(weight[5]),
        .weight_6(weight[6]), .weight_7(weight[7]), .weight_8(weight[8]),
        .weight_valid(weight_valid),
        .pix_0(pix[0]), .pix_1(pix[1]), .pix_2(pix[2]), .pix_3(pix[3]), .pix_4(pix[4]),
        .pix_5(pix[5]), .pix_6(pix[6]), .pix_7(pix[7]), .pix_8(pix[8]),
        .bias(bias), .in_valid(in_valid), .in_ready(in_ready0),
        .out_data(out_data0), .out_acc(out_acc0), .out_valid(out_valid0),
        .out_ready(out_ready), .kernel_loaded(kernel_loaded0)
    );

    conv33_mac_pipe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SHIFT(2)) dut2 (
        .clk(clk), .rst(rst),
        .weight_0(weight[0]), .weight_1(weight[1]), .weight_2(weight[2]),
        .weight_3(weight[3]), .weight_4(weight[4]), .weight_5(weight[5]),
        .weight_6(weight[6]), .weight_7(weight[7]), .weight_8(weight[8]),
        .weight_valid(weight_valid),
        .pix_0(pix[0]), .pix_1(pix[1]), .pix_2(pix[2]), .pix_3(pix[3]), .pix_4(pix[4]),
        .pix_5(pix[5]), .pix_6(pix[6]), .pix_7(pix[7]), .pix_8(pix[8]),
        .bias(bias), .in_valid(in_valid), .in_ready(in_ready2),
        .out_data(out_data2), .out_acc(out_acc2), .out_valid(out_valid2),
        .out_ready(out_ready), .kernel_loaded(kernel_loaded2)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint relu(input longint x);
`ifdef CONV33_MAC_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    // Round-half-up division by 2^s (floor of (acc + d/2) / d), then clamp.
    function automatic longint model_q(input longint acc, input int s);
        longint d, num, q;
        if (s == 0) begin
            q = acc;
        end else begin
            d   = longint'(1) << s;
            num = acc + d / 2;
            q   = num / d;
            if (num < 0 && (num % d) != 0)
                q = q - 1;
        end
        if (q > SAT_MAX) q = SAT_MAX;
        if (q < SAT_MIN) q = SAT_MIN;
        return relu(q);
    endfunction

    always @(negedge clk) begin
        bit     adv;
        longint s;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
            for (int i = 0; i < 9; i++) m_k[i] = 0;
            m_loaded = 1'b0;
            chk("rst_out_valid0", out_valid0, 0);
            chk("rst_out_valid2", out_valid2, 0);
            chk("rst_out_acc0", $signed(out_acc0), 0);
            chk("rst_out_data2", $signed(out_data2), 0);
            chk("rst_in_ready0", in_ready0, 0);
            chk("rst_kernel_loaded2", kernel_loaded2, 0);
        end else begin
            adv = !(m_vld[3] && !out_ready);
            chk("in_ready0", in_ready0, m_loaded && adv);
            chk("in_ready2", in_ready2, m_loaded && adv);
            chk("kernel_loaded0", kernel_loaded0, m_loaded);
            chk("out_valid0", out_valid0, m_vld[3]);
            chk("out_valid2", out_valid2, m_vld[3]);
            if (m_vld[3]) begin
                chk("out_acc0", $signed(out_acc0), m_acc[3]);
                chk("out_acc2", $signed(out_acc2), m_acc[3]);
                chk("out_data0", $signed(out_data0), model_q(m_acc[3], 0));
                chk("out_data2", $signed(out_data2), model_q(m_acc[3], 2));
                if (out_ready) begin
                    q_acc.push_back(m_acc[3]);
                    q_d0.push_back(model_q(m_acc[3], 0));
                    q_d2.push_back(model_q(m_acc[3], 2));
                end
            end
            s = $signed(bias);
            for (int i = 0; i < 9; i++)
                s += longint'($signed(pix[i])) * m_k[i];
            if (adv) begin
                for (int i = 3; i > 0; i--) begin
                    m_vld[i] = m_vld[i-1];
                    m_acc[i] = m_acc[i-1];
                end
                m_vld[0] = in_valid && m_loaded;
                m_acc[0] = s;
            end
            if (weight_valid) begin
                for (int i = 0; i < 9; i++) m_k[i] = longint'($signed(weight[i]));
                m_loaded = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int v);
        for (int i = 0; i < 9; i++) pix[i] = DW'(v);
    endtask

    task automatic load_kernel(input int v);
        for (int i = 0; i < 9; i++) weight[i] = DW'(v);
        weight_valid = 1'b1;
        tick();
        weight_valid = 1'b0;
    endtask

    task automatic send(input int v, input int b);
        set_pix(v);
        bias = AW'(b);
        in_valid = 1'b1;
        #1;
        for (int t = 0; t < 50 && !in_ready0; t++) begin
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int target);
        for (int t = 0; t < 60 && q_acc.size() < target; t++) tick();
        chk("result_count", q_acc.size(), target);
    endtask

    initial begin
        int idx;
        bit acc_now;
        for (int i = 0; i < 9; i++) begin
            weight[i] = '0;
            pix[i] = '0;
        end
        repeat (3) tick();
        rst = 1'b0;

        // No kernel yet: window must be refused.
        set_pix(3);
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        chk("no_out_unloaded", q_acc.size(), 0);

        // Kernel 1, window 2: latency and basic values.
        load_kernel(1);
        set_pix(2);
        bias = '0;
        in_valid = 1'b1;
        #1;
        chk("in_ready_loaded", in_ready0, 1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("latency_t3", out_valid0, 0);
        tick();
        chk("latency_t4", out_valid0, 1);
        chk("lit_acc_t4", $signed(out_acc0), 18);
        chk("lit_data2_t4", $signed(out_data2), 5);
        wait_res(1);
        chk("lit_acc18", q_acc[0], 18);
        chk("lit_d0_18", q_d0[0], 18);
        chk("lit_d2_5", q_d2[0], 5);

        send(2, -20);
        wait_res(2);
        chk("lit_acc_m2", q_acc[1], -2);
        chk("lit_d0_m2", q_d0[1], relu(-2));
        chk("lit_d2_m2", q_d2[1], 0);

        // Saturation extremes.
        load_kernel(127);
        send(127, 0);
        load_kernel(-128);
        send(127, 0);
        wait_res(4);
        chk("lit_acc_max", q_acc[2], 145161);
        chk("lit_d0_max", q_d0[2], 127);
        chk("lit_d2_max", q_d2[2], 127);
        chk("lit_acc_min", q_acc[3], -146304);
        chk("lit_d0_min", q_d0[3], relu(-128));
        chk("lit_d2_min", q_d2[3], relu(-128));

        // Back-to-back windows 1..5 with a 3-cycle stall on result 2.
        load_kernel(1);
        bias = '0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            in_valid = (idx < 5);
            set_pix(idx + 1);
            #1;
            if (c >= 5 && c <= 7) chk("stall_in_ready", in_ready0, 0);
            acc_now = in_valid && in_ready0;
            @(posedge clk);
            #1;
            if (acc_now) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_res(9);
        for (int i = 0; i < 5; i++) chk("lit_order", q_acc[4+i], 9 * (i + 1));

        // Kernel swap in the same cycle as an accept.
        for (int i = 0; i < 9; i++) weight[i] = DW'(3);
        weight_valid = 1'b1;
        set_pix(2);
        bias = AW'(7);
        in_valid = 1'b1;
        #1;
        chk("swap_ready_a", in_ready0, 1);
        tick();
        weight_valid = 1'b0;
        bias = '0;
        #1;
        chk("swap_ready_b", in_ready0, 1);
        tick();
        in_valid = 1'b0;
        wait_res(11);
        chk("lit_old_kernel", q_acc[9], 25);
        chk("lit_new_kernel", q_acc[10], 54);

        // Fill the pipe, hold output, then reset: nothing in flight may emerge.
        out_ready = 1'b0;
        set_pix(1);
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_valid", out_valid0, 1);
        rst = 1'b1;
        #1;
        chk("rst_imm_valid0", out_valid0, 0);
        chk("rst_imm_valid2", out_valid2, 0);
        chk("rst_imm_loaded", kernel_loaded0, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        repeat (6) tick();
        in_valid = 1'b0;
        chk("discarded", q_acc.size(), 11);
        load_kernel(1);
        send(1, 0);
        wait_res(12);
        chk("lit_after_rst", q_acc[11], 9);

        // Randomized traffic with kernel reloads and backpressure.
        for (int c = 0; c < 400; c++) begin
            weight_valid = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 9; i++) begin
                weight[i] = DW'($urandom);
                pix[i] = DW'($urandom);
            end
            in_valid = ($urandom_range(0, 9) < 7);
            bias = AW'(int'($urandom_range(0, 8191)) - 4096);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        weight_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
